// File: rtl/uart8_receiver_pkg.sv
// Shared definitions for the UART link: state codes and the default
// oversampling ratio, so the transmitter-side baud divider and the receiver
// agree on a single value.
package uart8_receiver_pkg;

  // Clock cycles per bit period (must be even and >= 4).
  localparam int unsigned OversampleDefault = 16;

  // Link state codes shared by transmitter and receiver.
  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StIdle     = 3'd1,
    StStartBit = 3'd2,
    StDataBits = 3'd3,
    StStopBit  = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a previous-value
// flop used for falling-edge detection. All flops reset to 1 (idle line).
//   clk    : sampling clock
//   rst    : asynchronous, active-high reset
//   rx     : raw asynchronous serial input
//   rx_s   : synchronised rx
//   rx_s_d : rx_s delayed by one cycle
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_s_d
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      meta   <= rx;
      rx_s   <= meta;
      rx_s_d <= rx_s;
    end
  end

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver, LSB first, running on an oversampled clock. Each bit is
// sampled at its midpoint; a good frame updates out with a one-cycle done
// pulse, a zero stop bit gives a one-cycle err pulse and leaves out alone.
//   clk  : oversampled clock (OVERSAMPLE x baud)
//   rst  : asynchronous, active-high reset
//   en   : tick enable; 0 freezes FSM, counters and data (sync keeps running)
//   rx   : asynchronous serial line, idle high
//   out  : last correctly received byte
//   done : one-cycle pulse, out holds a new byte
//   err  : one-cycle pulse, framing error
//   busy : frame reception in progress
module uart8_receiver
  import uart8_receiver_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OversampleDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] out,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] MidCnt = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] EndCnt = CntW'(OVERSAMPLE - 1);

  uart_state_e     state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      data;
  logic            rx_s;
  logic            rx_s_d;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_s   (rx_s),
    .rx_s_d (rx_s_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      bit_idx <= 3'd0;
      data    <= 8'h00;
      out     <= 8'h00;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (en) begin
        case (state)
          StIdle: begin
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= 3'd0;
            // Edge-triggered so a held-low line (break) never starts a frame.
            if (rx_s_d && !rx_s) begin
              state <= StStartBit;
              busy  <= 1'b1;
            end
          end
          StStartBit: begin
            if (cnt == MidCnt) begin
              cnt <= '0;
              if (!rx_s) begin
                state <= StDataBits;
              end else begin
                // Line went high again before mid start bit: glitch.
                state <= StIdle;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StDataBits: begin
            if (cnt == EndCnt) begin
              cnt           <= '0;
              data[bit_idx] <= rx_s;
              if (bit_idx == 3'd7) begin
                bit_idx <= 3'd0;
                state   <= StStopBit;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StStopBit: begin
            if (cnt == EndCnt) begin
              cnt   <= '0;
              busy  <= 1'b0;
              state <= StIdle;
              if (rx_s) begin
                out  <= data;
                done <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            // StReset and unused encodings fall back to idle.
            state   <= StIdle;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart8_receiver.sv
// Self-checking bench for uart8_receiver: serial frames are generated from
// byte values, and a scoreboard predicts each done/err pulse (kind, cycle,
// out value) from frame start time, stall length and stop-bit validity.
module tb_uart8_receiver;

  localparam int unsigned Os = 16;
  localparam int unsigned Latency = 3 + (19 * Os) / 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rx;
  logic [7:0] out;
  logic       done;
  logic       err;
  logic       busy;

  uart8_receiver #(
    .OVERSAMPLE (Os)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .rx   (rx),
    .out  (out),
    .done (done),
    .err  (err),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        en_seen = 1'b1;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_seen <= en;
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_err;
    int unsigned at;
    logic [7:0]  val;
  } evt_t;

  evt_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  // Predict the outcome of one frame whose start bit begins at cycle start.
  function automatic void expect_frame(input logic [7:0] b, input bit stop_ok,
                                       input int unsigned start, input int unsigned stall);
    evt_t e;
    if (stop_ok) last_good = b;
    e.is_err = !stop_ok;
    e.at     = start + Latency + stall;
    e.val    = last_good;
    exp_q.push_back(e);
  endfunction

  // Hold rx at v for one bit period, counting only enabled clock cycles.
  task automatic drive_bit(input logic v);
    int unsigned n;
    rx = v;
    n  = 0;
    while (n < Os) begin
      @(negedge clk);
      if (en_seen) n++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit track,
                            input int unsigned stall);
    if (track) expect_frame(b, stop_ok, cyc, stall);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check_eq("pulse_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
        check_eq("pulse_cycle", cyc, e.at);
        check_eq("out_value", {24'd0, out}, {24'd0, e.val});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    rst = 1'b1;
    en  = 1'b1;
    rx  = 1'b1;
    #2;
    check_eq("reset_out", {24'd0, out}, 32'd0);
    check_eq("reset_flags", {29'd0, done, err, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte with busy window.
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      begin
        repeat (2) @(negedge clk);
        check_eq("a5_busy_e2", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("a5_busy_e3", {31'd0, busy}, 32'd1);
        repeat (Latency - 4) @(negedge clk);
        check_eq("a5_busy_e154", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("a5_busy_e155", {31'd0, busy}, 32'd0);
        check_eq("a5_done_cycle", cyc - c0, Latency);
      end
    join
    drive_bit(1'b1);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    drive_bit(1'b1);

    // Framing error, then a steady low line.
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    rx = 1'b0;
    repeat (20 * Os) @(negedge clk);
    check_eq("break_busy", {31'd0, busy}, 32'd0);
    check_eq("break_out", {24'd0, out}, 32'h0000_00FF);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Four-cycle low glitch.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("glitch_busy_e3", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("glitch_busy_e10", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("glitch_busy_e11", {31'd0, busy}, 32'd0);
    repeat (2 * Os) @(negedge clk);

    // en dropped for 20 cycles in the middle of data bit 3.
    fork
      send_frame(8'h5A, 1'b1, 1'b1, 20);
      begin
        repeat (Os * 4 + Os / 2 - 2) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
      end
    join
    drive_bit(1'b1);

    // Asynchronous reset during data bits.
    fork
      send_frame(8'h77, 1'b1, 1'b0, 0);
      begin
        repeat (3 * Os) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_out", {24'd0, out}, 32'd0);
        check_eq("rst_flags", {29'd0, done, err, busy}, 32'd0);
      end
    join
    last_good = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b1, 0);
    drive_bit(1'b1);

    // Randomized frames with random gaps and occasional bad stop bits.
    for (int k = 0; k < 30; k++) begin
      logic [7:0]  b;
      bit          ok;
      int unsigned gap;
      b   = 8'($urandom);
      ok  = ($urandom_range(3) != 0);
      gap = ok ? $urandom_range(2) : $urandom_range(3, 1);
      send_frame(b, ok, 1'b1, 0);
      for (int g = 0; g < int'(gap); g++) drive_bit(1'b1);
    end

    rx = 1'b1;
    repeat (12 * Os) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    check_eq("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart8_receiver.md
Name: uart8_receiver

Overview:
- 8-bit UART receiver, 8N1 frames, LSB first. Downstream consumer of the 8-bit UART transmitter's serial line (loopback / host link).
- Runs on an oversampled clock (OVERSAMPLE ticks per bit), synchronises the asynchronous rx line and samples each bit at mid-bit.
- Presents each received byte with a one-cycle done pulse and flags framing errors.
- Feeds the matrix-data loader that sits behind the UART.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit period. Must be even and >= 4.

Ports:
- clk   input   1  oversampled clock (OVERSAMPLE x baud rate)
- rst   input   1  asynchronous, active-high reset
- en    input   1  tick enable; 0 freezes state, counters and data register
- rx    input   1  serial line, asynchronous, idle high
- out   output  8  last correctly received byte
- done  output  1  one-cycle pulse: out updated with a valid byte
- err   output  1  one-cycle pulse: framing error (stop bit sampled 0)
- busy  output  1  frame reception in progress

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE, out=8'h00, done=0, err=0, busy=0, bit index=0, sample counter=0, data shift register=0, synchroniser flops and previous-rx flop=1. The frame in progress is discarded.
- Synchroniser: rx passes through two flops to give rx_s; rx_s_d holds the previous rx_s value. All decisions use rx_s only.
- done and err default to 0 every cycle; each asserts for exactly one cycle.
- en=0: the FSM, counters, data register and out hold their values; done and err still fall to 0. The synchroniser keeps running.
- IDLE:
  - busy=0, counter=0, bit index=0.
  - On a falling edge (rx_s_d=1 and rx_s=0) with en=1: go to START_BIT, busy=1.
  - A steady low line (break, or after a framing error) never starts a frame.
- START_BIT:
  - Counter increments each enabled cycle.
  - When counter = OVERSAMPLE/2-1 (mid start bit): if rx_s=0, go to DATA_BITS with counter=0; otherwise treat as a glitch and go to IDLE with busy=0. No done or err in the glitch case.
- DATA_BITS:
  - When counter = OVERSAMPLE-1: data[bit index] <= rx_s and counter=0.
  - If bit index=7: bit index=0 and go to STOP_BIT. Otherwise bit index+1.
  - Before OVERSAMPLE-1, the counter increments.
- STOP_BIT:
  - When counter = OVERSAMPLE-1, sample rx_s.
  - If 1: out <= data, done=1.
  - If 0: err=1 and out unchanged.
  - In both cases busy=0 and go to IDLE.
- Latency: done/err is registered on enabled edge N = 3 + 9.5*OVERSAMPLE (155 for 16). Edge 1 is the first edge at which rx is sampled low.
- Back-to-back frames: a new start bit beginning right after the stop-bit midpoint is accepted, because IDLE is re-entered before the next falling edge.
- Unused or illegal state encodings recover to IDLE on the next enabled edge.
- Counter width is $clog2(OVERSAMPLE). The bit index is 3 bits and wraps only by explicit reset to 0.

Decomposition:
- Reuse the shared UartStates.vh state codes (RESET, IDLE, START_BIT, DATA_BITS, STOP_BIT). No new state codes.
- OVERSAMPLE default goes in the same header as a shared define, so the transmitter-side baud divider and the receiver agree.
- One sub-module: uart_rx_sync, the 2-flop synchroniser plus previous-value flop, with async reset to 1.

Test Plan:
- Single byte 8'hA5 at OVERSAMPLE=16 with en=1 -> done pulses for one cycle at edge 155, out=8'hA5, err=0; busy is high from edge 3 through edge 155.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two done pulses 160 cycles apart, out=8'h00 then 8'hFF.
- Stop bit forced to 0 on byte 8'h3C -> err pulses once, done stays 0, out keeps its previous value; a steady low line afterwards produces no further frames.
- rx low glitch of 4 cycles -> FSM returns to IDLE at the start-bit midpoint; no done, no err, busy is low again within 8 cycles of the glitch's detection.
- Frame 8'h5A with en deasserted for 20 cycles mid-bit-3 -> still received correctly; done arrives 20 cycles later than nominal.
- rst asserted mid-DATA_BITS -> all outputs 0 immediately (asynchronously); the next clean frame 8'h81 is received correctly.
